// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types and constants for the instruction queue / issue sequencer.
package issue_queue_ctrl_pkg;

  typedef logic [31:0] WORD_TP;
  typedef logic [31:0] ADDR_TP;

  localparam logic   TRUE      = 1'b1;
  localparam logic   FALSE     = 1'b0;
  localparam WORD_TP ZERO_WORD = '0;

  typedef struct packed {
    WORD_TP inst;
    ADDR_TP cur_pc;
    ADDR_TP mis_pc;
    logic   pb_tk_stat;
  } iq_entry_t;

  localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/issue_queue_ctrl_if.sv
// IFU push side, ROB rollback and dispatcher handshake of the issue queue.
interface issue_queue_ctrl_if;
  import issue_queue_ctrl_pkg::*;

  logic   if_valid;
  WORD_TP if_inst;
  ADDR_TP if_cur_pc;
  ADDR_TP if_mis_pc;
  logic   if_pb_tk_stat;
  logic   iq_full;

  logic   rob_rb;
  logic   id_full;
  logic   id_en;
  logic   id_st;
  logic   id_rb;

  logic   disp_valid;
  WORD_TP disp_inst;
  ADDR_TP disp_cur_pc;
  ADDR_TP disp_mis_pc;
  logic   disp_pb_tk_stat;

  modport master (
    output if_valid, if_inst, if_cur_pc, if_mis_pc, if_pb_tk_stat,
    output rob_rb, id_full,
    input  iq_full, id_en, id_st, id_rb,
    input  disp_valid, disp_inst, disp_cur_pc, disp_mis_pc, disp_pb_tk_stat
  );

  modport slave (
    input  if_valid, if_inst, if_cur_pc, if_mis_pc, if_pb_tk_stat,
    input  rob_rb, id_full,
    output iq_full, id_en, id_st, id_rb,
    output disp_valid, disp_inst, disp_cur_pc, disp_mis_pc, disp_pb_tk_stat
  );

endinterface

// File: rtl/issue_queue_ctrl_sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 97,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Cleared on reset so the head outputs read as zero while the queue is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/issue_queue_ctrl.sv
// Instruction queue between IFU and dispatcher: buffers fetched instructions,
// presents the head entry, pops on dispatcher acceptance and flushes on ROB rollback.
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int unsigned IQ_DEPTH  = 8,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  issue_queue_ctrl_if.slave    iq
);

  localparam int unsigned AW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(IQ_DEPTH);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(1);

  logic [1:0]    state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [FW-1:0] flush_cnt;

  logic          in_run;
  logic          push;
  logic          pop;
  iq_entry_t     wr_entry;
  iq_entry_t     head_entry;

  assign in_run = (state == ST_RUN);

  // Dispatcher controls.
  assign iq.id_en = (state == ST_RUN) || (state == ST_FLUSH);
  assign iq.id_rb = (state == ST_FLUSH) ? TRUE : FALSE;
  assign iq.id_st = iq.id_full || !rdy;

  assign iq.disp_valid      = (count != '0) && in_run;
  assign iq.disp_inst       = head_entry.inst;
  assign iq.disp_cur_pc     = head_entry.cur_pc;
  assign iq.disp_mis_pc     = head_entry.mis_pc;
  assign iq.disp_pb_tk_stat = head_entry.pb_tk_stat;

  assign iq.iq_full = (count >= DEPTH_C - 1'b1) || !in_run;

  assign pop  = iq.disp_valid && iq.id_en && !iq.id_st && !iq.id_rb && rdy;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = iq.if_valid && rdy && in_run && !iq.rob_rb &&
                ((count < DEPTH_C) || pop);

  assign wr_entry = '{
    inst:       iq.if_inst,
    cur_pc:     iq.if_cur_pc,
    mis_pc:     iq.if_mis_pc,
    pb_tk_stat: iq.if_pb_tk_stat
  };

  sync_fifo_mem #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (IQ_ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (tail),
    .wr_data (wr_entry),
    .rd_addr (head),
    .rd_data (head_entry)
  );

  // Pointers and occupancy; rollback overrides any push or pop of the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (iq.rob_rb) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else if (rdy) begin
      if (iq.rob_rb) begin
        state     <= ST_FLUSH;
        flush_cnt <= FLUSH_LOAD;
      end else begin
        case (state)
          ST_IDLE:  state <= ST_RUN;
          ST_RUN:   state <= ST_RUN;
          ST_FLUSH: begin
            if (flush_cnt <= FLUSH_LAST) begin
              state     <= ST_RUN;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  logic ovf_attempt;
  assign ovf_attempt = iq.if_valid && rdy && in_run && !iq.rob_rb &&
                       (count == DEPTH_C) && !pop;

  iq_overflow: assert property (@(posedge clk) disable iff (!rst) !ovf_attempt)
    else $warning("iq_overflow: push dropped with the queue at capacity");
`endif

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed bench for issue_queue_ctrl: a vector table for basic issue, then multi-cycle sequences.
module tb_issue_queue_ctrl;
  import issue_queue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  issue_queue_ctrl_if bus ();

  issue_queue_ctrl #(
    .IQ_DEPTH  (8),
    .FLUSH_CYC (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .iq  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    string       name;
    logic        rdy;
    logic        ifv;
    logic [31:0] pc;
    logic        rb;
    logic        idf;
    logic        e_full;
    logic        e_dv;
    logic [31:0] e_pc;
    logic        e_en;
    logic        e_st;
    logic        e_rb;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] mis_of(input logic [31:0] pc);
    return pc + 32'h0000_0040;
  endfunction

  function automatic logic pb_of(input logic [31:0] pc);
    return pc[2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic rb, input logic f);
    rdy               = r;
    bus.if_valid      = v;
    bus.if_cur_pc     = pc;
    bus.if_inst       = inst_of(pc);
    bus.if_mis_pc     = mis_of(pc);
    bus.if_pb_tk_stat = pb_of(pc);
    bus.rob_rb        = rb;
    bus.id_full       = f;
  endtask

  task automatic check_out(input string nm, input logic e_full, input logic e_dv,
                           input logic [31:0] e_pc, input logic e_en,
                           input logic e_st, input logic e_rb);
    chk({nm, ".iq_full"},    32'(bus.iq_full),    32'(e_full));
    chk({nm, ".disp_valid"}, 32'(bus.disp_valid), 32'(e_dv));
    chk({nm, ".id_en"},      32'(bus.id_en),      32'(e_en));
    chk({nm, ".id_st"},      32'(bus.id_st),      32'(e_st));
    chk({nm, ".id_rb"},      32'(bus.id_rb),      32'(e_rb));
    if (e_dv) begin
      chk({nm, ".disp_cur_pc"}, bus.disp_cur_pc,           e_pc);
      chk({nm, ".disp_inst"},   bus.disp_inst,             inst_of(e_pc));
      chk({nm, ".disp_mis_pc"}, bus.disp_mis_pc,           mis_of(e_pc));
      chk({nm, ".disp_pb"},     32'(bus.disp_pb_tk_stat),  32'(pb_of(e_pc)));
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
  task automatic step(input string nm, input logic r, input logic v, input logic [31:0] pc,
                      input logic rb, input logic f,
                      input logic e_full, input logic e_dv, input logic [31:0] e_pc,
                      input logic e_en, input logic e_st, input logic e_rb);
    @(negedge clk);
    drive(r, v, pc, rb, f);
    #1;
    check_out(nm, e_full, e_dv, e_pc, e_en, e_st, e_rb);
  endtask

  task automatic check_reset_state(input string nm);
    check_out(nm, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk({nm, ".disp_cur_pc"}, bus.disp_cur_pc,          32'h0);
    chk({nm, ".disp_inst"},   bus.disp_inst,            32'h0);
    chk({nm, ".disp_mis_pc"}, bus.disp_mis_pc,          32'h0);
    chk({nm, ".disp_pb"},     32'(bus.disp_pb_tk_stat), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] expq [$];
    logic [31:0] pc;

    //        name         rdy ifv pc      rb idf  full dv pc      en st rb
    tbl[0] = '{"t1_idle",  1, 0, 32'h0,  0, 0,   1,  0, 32'h0,  0, 0, 0};
    tbl[1] = '{"t1_push0", 1, 1, 32'h0,  0, 0,   0,  0, 32'h0,  1, 0, 0};
    tbl[2] = '{"t1_push4", 1, 1, 32'h4,  0, 0,   0,  1, 32'h0,  1, 0, 0};
    tbl[3] = '{"t1_push8", 1, 1, 32'h8,  0, 0,   0,  1, 32'h4,  1, 0, 0};
    tbl[4] = '{"t1_last",  1, 0, 32'h0,  0, 0,   0,  1, 32'h8,  1, 0, 0};
    tbl[5] = '{"t1_empty", 1, 0, 32'h0,  0, 0,   0,  0, 32'h0,  1, 0, 0};
    tbl[6] = '{"t1_stall", 1, 0, 32'h0,  0, 1,   0,  0, 32'h0,  1, 1, 0};
    tbl[7] = '{"t1_nordy", 0, 0, 32'h0,  0, 0,   0,  0, 32'h0,  1, 1, 0};

    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    // Basic issue: three pushes presented one per cycle, then stall controls.
    for (int unsigned i = 0; i < 8; i++) begin
      step(tbl[i].name, tbl[i].rdy, tbl[i].ifv, tbl[i].pc, tbl[i].rb, tbl[i].idf,
           tbl[i].e_full, tbl[i].e_dv, tbl[i].e_pc, tbl[i].e_en, tbl[i].e_st, tbl[i].e_rb);
    end

    // Fill to capacity behind a stalled dispatcher; the 9th push is dropped.
    for (int unsigned k = 0; k < 8; k++) begin
      step($sformatf("t2_fill%0d", k), 1, 1, 32'h100 + 4 * k, 0, 1,
           (k >= 7), (k > 0), 32'h100, 1, 1, 0);
    end
    step("t2_ovf", 1, 1, 32'h900, 0, 1, 1, 1, 32'h100, 1, 1, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      step($sformatf("t2_drain%0d", i), 1, 0, 32'h0, 0, 0,
           (i < 2), 1, 32'h100 + 4 * i, 1, 0, 0);
    end
    step("t2_empty", 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0);

    // Steady push+pop at occupancy 4; pointers wrap past the end of the array.
    for (int unsigned k = 0; k < 4; k++) begin
      pc = 32'h200 + 4 * k;
      step($sformatf("t3_fill%0d", k), 1, 1, pc, 0, 1, 0, (k > 0), 32'h200, 1, 1, 0);
      expq.push_back(pc);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      pc = 32'h300 + 4 * i;
      step($sformatf("t3_pp%0d", i), 1, 1, pc, 0, 0, 0, 1, expq[0], 1, 0, 0);
      void'(expq.pop_front());
      expq.push_back(pc);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      step($sformatf("t3_drain%0d", i), 1, 0, 32'h0, 0, 0, 0, 1, expq[0], 1, 0, 0);
      void'(expq.pop_front());
    end
    step("t3_empty", 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0);

    // Rollback at occupancy 5 together with a push; then rollback reload while flushing.
    for (int unsigned k = 0; k < 5; k++) begin
      step($sformatf("t4_fill%0d", k), 1, 1, 32'h400 + 4 * k, 0, 1, 0, (k > 0), 32'h400, 1, 1, 0);
    end
    step("t4_rb",       1, 1, 32'h500, 1, 0, 0, 1, 32'h400, 1, 0, 0);
    step("t4_flush",    1, 1, 32'h504, 0, 0, 1, 0, 32'h0,   1, 0, 1);
    step("t4_resume",   1, 1, 32'h600, 0, 0, 0, 0, 32'h0,   1, 0, 0);
    step("t4_issue",    1, 0, 32'h0,   0, 0, 0, 1, 32'h600, 1, 0, 0);
    step("t4_idle",     1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 0);
    step("t4_rb2",      1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 0, 0);
    step("t4_flush_rb", 1, 0, 32'h0,   1, 0, 1, 0, 32'h0,   1, 0, 1);
    step("t4_reload",   1, 0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 1);
    step("t4_run",      1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 0);

    // rdy low freezes the queue with two entries and a pending push.
    step("t5_fill0", 1, 1, 32'h700, 0, 1, 0, 0, 32'h0,   1, 1, 0);
    step("t5_fill1", 1, 1, 32'h704, 0, 1, 0, 1, 32'h700, 1, 1, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step($sformatf("t5_frz%0d", i), 0, 1, 32'h7F0, 0, 0, 0, 1, 32'h700, 1, 1, 0);
    end
    step("t5_pop0",  1, 0, 32'h0, 0, 0, 0, 1, 32'h700, 1, 0, 0);
    step("t5_pop1",  1, 0, 32'h0, 0, 0, 0, 1, 32'h704, 1, 0, 0);
    step("t5_empty", 1, 0, 32'h0, 0, 0, 0, 0, 32'h0,   1, 0, 0);

    // Reset mid-stream with six entries queued.
    for (int unsigned k = 0; k < 6; k++) begin
      step($sformatf("t6_fill%0d", k), 1, 1, 32'h800 + 4 * k, 0, 1, 0, (k > 0), 32'h800, 1, 1, 0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 check_reset_state("t6_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    step("t6_idle",  1, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 0, 0);
    step("t6_run",   1, 1, 32'hA00, 0, 0, 0, 0, 32'h0,   1, 0, 0);
    step("t6_issue", 1, 0, 32'h0,   0, 0, 0, 1, 32'hA00, 1, 0, 0);
    step("t6_empty", 1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
